ram_dp_be: RTL and testbench
============================

# ram_dp_be

Parametrised dual-port RAM with one read/write port (A) and one read-only port (B). Adds per-byte write enables, selectable read latency (0/1/2), a read-during-write policy, and a hardware clear sweep after reset. It is the general memory primitive for register files, scratchpads and FIFO storage in the design, and supersedes the single-port asynchronous RAM.

## Interface
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word bits; must be a multiple of 8; NB = DATA_WIDTH/8
- READ_LATENCY, 1, cycles from read request to rvalid: 0, 1 or 2
- RDW_MODE, 0, same-edge read/write to one address: 0 = read-first (old word), 1 = write-first (merged new word)
- INIT_VALUE, 0, word written to every location by the clear sweep

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ready  out  1  high once the clear sweep is done; requests ignored while low
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_be  in  NB  byte enables; bit k covers bits 8k+7:8k
- a_write  in  1  write request
- a_read  in  1  read request
- a_rdata  out  DATA_WIDTH  port A read data
- a_rvalid  out  1  a_rdata valid this cycle
- b_addr  in  ADDR_WIDTH  port B address
- b_read  in  1  read request
- b_rdata  out  DATA_WIDTH  port B read data
- b_rvalid  out  1  b_rdata valid this cycle

## Operation
- FSM states: INIT, RUN.
- rst_n low at an edge: state goes to INIT and sweep counter to 0. ready, a_rvalid, b_rvalid, and all read pipeline valid bits are cleared. Registered rdata outputs are set to 0.
- INIT with rst_n high: each cycle, write INIT_VALUE to mem[counter] and increment. The edge that writes address 2**ADDR_WIDTH-1 moves the FSM to RUN.
- RUN: ready = 1.
  - a_write: for each k with a_be[k]=1, byte k of mem[a_addr] takes byte k of a_wdata. Other bytes are unchanged. a_be = 0 means no change.
  - a_read / b_read: issue a read of a_addr / b_addr. Reads and writes may be asserted together on port A.
- Requests while ready = 0 are dropped: no memory change and no rvalid.
- Read-during-write: a read on A or B of the address written by A in the same cycle returns:
  - RDW_MODE 0: the pre-write word.
  - RDW_MODE 1: the byte-merged post-write word.
- Both ports reading the same address is always legal.
- rdata holds its last value when no read completes. It is never cleared except by reset (for latency ≥ 1).
- A reset mid-sweep or mid-read restarts the sweep at address 0 and flushes in-flight reads.

## Timing
- Clear sweep: ready rises exactly 2**ADDR_WIDTH cycles after the first edge with rst_n high.
- READ_LATENCY 0:
  - rdata = mem[addr] combinationally; rvalid = read & ready combinationally.
  - RDW_MODE applies only to data visible after the edge: before the edge, rdata shows the old word.
- READ_LATENCY 1: request sampled at edge N; rdata and rvalid are valid after edge N, for one cycle.
- READ_LATENCY 2: one more output register; valid after edge N+1.
- Reads are fully pipelined: one request per port per cycle, with results in order.
- Writes take effect at the sampling edge; a read issued on the next cycle sees the new data.

## Structure
- Shared package ram_pkg:
  - RDW_READ_FIRST / RDW_WRITE_FIRST constants
  - state enum {INIT, RUN}
  - byte-merge function (old, wdata, be) -> word
- Sub-module ram_rd_pipe:
  - parametrised delay line for data plus valid, depth READ_LATENCY
  - has a sync active-low flush
  - instantiated once per port
- The memory array and sweep FSM live in the top level.

## Test plan
- Reset then idle: ready is 0 for 1024 cycles, then 1. Reading addresses 0, 511 and 1023 returns 0x00000000.
- Byte enables: write 0xAABBCCDD with be=4'b1111, then 0x11223344 with be=4'b0101 to addr 5. Reading addr 5 returns 0xAA22CC44.
- Read-during-write: mem[7] = 0x1, then same-cycle A write 0x2 to addr 7 with B read of addr 7. RDW_MODE 0 gives b_rdata = 0x1; RDW_MODE 1 gives 0x2.
- Latency sweep, run for 0/1/2: back-to-back reads of addr 1, 2, 3 on both ports. rvalid appears at the stated latency, data is in order, and no bubbles occur.
- Gating and mid-sweep reset:
  - Writes and reads during INIT produce no rvalid and do not alter memory.
  - Asserting rst_n low at sweep count 300 restarts the sweep; ready rises 1024 cycles after release.
  - In-flight reads at reset produce no rvalid.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, FSM state type and byte-merge helper for ram_dp_be
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers cast their words to and from this width.
    localparam int MERGE_MAX_DW = 1024;
    localparam int MERGE_NB     = MERGE_MAX_DW / 8;

    typedef enum logic {
        INIT,
        RUN
    } ram_state_e;

    // Byte k of the result is wdata byte k when be[k] is set, otherwise old byte k.
    function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
        input logic [MERGE_MAX_DW-1:0] old_w,
        input logic [MERGE_MAX_DW-1:0] wdata,
        input logic [MERGE_NB-1:0]     be
    );
        logic [MERGE_MAX_DW-1:0] res;
        res = old_w;
        for (int k = 0; k < MERGE_NB; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - read-result delay line (data plus valid) with synchronous flush
//
// Ports:
//   clk        clock
//   flush_n    synchronous active-low flush: clears valids and zeroes data stages
//   in_valid   read issued this cycle
//   in_data    word read this cycle
//   out_valid  result valid, LATENCY cycles after issue
//   out_data   result word; holds its last value when no result completes
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  flush_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (LATENCY == 0) begin : g_comb
            logic unused_ok;
            assign unused_ok = clk ^ flush_n;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_reg
            logic [LATENCY-1:0]    valid_q;
            logic [DATA_WIDTH-1:0] data_q [LATENCY];

            // Each data stage only loads when a valid result arrives, so the
            // output word holds between reads instead of streaming garbage.
            always_ff @(posedge clk) begin
                if (!flush_n) begin
                    valid_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
                    for (int i = 1; i < LATENCY; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        if (valid_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end

            assign out_valid = valid_q[LATENCY-1];
            assign out_data  = data_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - dual-port RAM (A read/write, B read-only) with byte enables and clear sweep
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ready               high once the clear sweep has finished; requests are dropped while low
//   a_addr, a_wdata     port A address and write data
//   a_be                port A byte enables (bit k covers byte k)
//   a_write, a_read     port A write / read requests
//   a_rdata, a_rvalid   port A read result
//   b_addr, b_read      port B address / read request
//   b_rdata, b_rvalid   port B read result
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    READ_LATENCY = 1,
    parameter int                    RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic                    a_write,
    input  logic                    a_read,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic                    b_read,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Write-first forwarding only makes sense when the result is registered;
    // a combinational read always shows the pre-edge word.
    localparam bit FWD_WRITE = (RDW_MODE == RDW_WRITE_FIRST) && (READ_LATENCY != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    ram_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    logic                  wr_en;
    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [DATA_WIDTH-1:0] a_old;
    logic [DATA_WIDTH-1:0] b_old;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] a_issue;
    logic [DATA_WIDTH-1:0] b_issue;

    assign ready   = (state_q == RUN);
    assign wr_en   = ready & a_write;
    assign a_rd_en = ready & a_read;
    assign b_rd_en = ready & b_read;

    assign a_old   = mem_q[a_addr];
    assign b_old   = mem_q[b_addr];
    assign wr_word = DATA_WIDTH'(byte_merge(MERGE_MAX_DW'(a_old), MERGE_MAX_DW'(a_wdata),
                                            MERGE_NB'(a_be)));

    assign a_issue = (FWD_WRITE && wr_en) ? wr_word : a_old;
    assign b_issue = (FWD_WRITE && wr_en && (b_addr == a_addr)) ? wr_word : b_old;

    // Sweep FSM and memory writes share one block: INIT owns the write port
    // until the last address is cleared, then port A takes over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    mem_q[cnt_q] <= INIT_VALUE;
                    cnt_q        <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        mem_q[a_addr] <= wr_word;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY   (READ_LATENCY)
    ) u_a_pipe (
        .clk      (clk),
        .flush_n  (rst_n),
        .in_valid (a_rd_en),
        .in_data  (a_issue),
        .out_valid(a_rvalid),
        .out_data (a_rdata)
    );

    ram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY   (READ_LATENCY)
    ) u_b_pipe (
        .clk      (clk),
        .flush_n  (rst_n),
        .in_valid (b_rd_en),
        .in_data  (b_issue),
        .out_valid(b_rvalid),
        .out_data (b_rdata)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - self-checking bench for ram_dp_be at read latencies 0, 1 and 2
module tb_ram_dp_be;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata;
    logic [NB-1:0] a_be;
    logic          a_write, a_read, b_read;

    logic          rdy0, rdy1, rdy2;
    logic [DW-1:0] ad0, bd0, ad1, bd1, ad2, bd2;
    logic          av0, bv0, av1, bv1, av2, bv2;

    always #5 clk = ~clk;

    // u_l0: latency 0 read-first, u_l1: latency 1 read-first, u_l2: latency 2 write-first
    ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0), .RDW_MODE(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy0),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_write(a_write), .a_read(a_read),
        .a_rdata(ad0), .a_rvalid(av0), .b_addr(b_addr), .b_read(b_read),
        .b_rdata(bd0), .b_rvalid(bv0));

    ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0)) u_l1 (
        .clk(clk), .rst_n(rst_n), .ready(rdy1),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_write(a_write), .a_read(a_read),
        .a_rdata(ad1), .a_rvalid(av1), .b_addr(b_addr), .b_read(b_read),
        .b_rdata(bd1), .b_rvalid(bv1));

    ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .ready(rdy2),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_write(a_write), .a_read(a_read),
        .a_rdata(ad2), .a_rvalid(av2), .b_addr(b_addr), .b_read(b_read),
        .b_rdata(bd2), .b_rvalid(bv2));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %08h required %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic          started = 1'b0;
    logic          m_ready;
    int            m_cnt;
    // issue record from the previous edge (feeds the latency-2 expectation)
    logic          p_av, p_bv;
    logic [DW-1:0] p_an, p_bn;
    // expected registered outputs after the current edge
    logic          e1_av, e1_bv, e2_av, e2_bv;
    logic [DW-1:0] e1_ad, e1_bd, e2_ad, e2_bd;
    // scratch
    logic          pre_ready, t_av, t_bv, t_wr;
    logic [DW-1:0] t_ao, t_bo, t_merged, t_an, t_bn;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1'b1;
            m_ready = 1'b0;
            m_cnt   = 0;
            p_av = 1'b0; p_bv = 1'b0; p_an = '0; p_bn = '0;
            e1_av = 1'b0; e1_bv = 1'b0; e1_ad = '0; e1_bd = '0;
            e2_av = 1'b0; e2_bv = 1'b0; e2_ad = '0; e2_bd = '0;
        end else if (started) begin
            pre_ready = m_ready;
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_ready = 1'b1;
                    foreach (ref_mem[i]) ref_mem[i] = '0;
                end
            end
            t_av = pre_ready & a_read;
            t_bv = pre_ready & b_read;
            t_wr = pre_ready & a_write;
            t_ao = ref_mem[a_addr];
            t_bo = ref_mem[b_addr];
            t_merged = t_ao;
            for (int k = 0; k < NB; k++)
                if (a_be[k]) t_merged[8*k +: 8] = a_wdata[8*k +: 8];
            t_an = t_wr ? t_merged : t_ao;
            t_bn = (t_wr && (b_addr == a_addr)) ? t_merged : t_bo;
            if (t_wr) ref_mem[a_addr] = t_merged;
            // latency 2, write-first: results of the previous edge's reads
            e2_av = p_av; if (p_av) e2_ad = p_an;
            e2_bv = p_bv; if (p_bv) e2_bd = p_bn;
            // latency 1, read-first: results of this edge's reads
            e1_av = t_av; if (t_av) e1_ad = t_ao;
            e1_bv = t_bv; if (t_bv) e1_bd = t_bo;
            p_av = t_av; p_an = t_an;
            p_bv = t_bv; p_bn = t_bn;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready_l0", rdy0, m_ready);
            check("ready_l1", rdy1, m_ready);
            check("ready_l2", rdy2, m_ready);
            check("l1_a_rvalid", av1, e1_av);
            check("l1_a_rdata",  ad1, e1_ad);
            check("l1_b_rvalid", bv1, e1_bv);
            check("l1_b_rdata",  bd1, e1_bd);
            check("l2_a_rvalid", av2, e2_av);
            check("l2_a_rdata",  ad2, e2_ad);
            check("l2_b_rvalid", bv2, e2_bv);
            check("l2_b_rdata",  bd2, e2_bd);
            check("l0_a_rvalid", av0, a_read & m_ready);
            check("l0_b_rvalid", bv0, b_read & m_ready);
            if (m_ready && a_read) check("l0_a_rdata", ad0, ref_mem[a_addr]);
            if (m_ready && b_read) check("l0_b_rdata", bd0, ref_mem[b_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        a_write = 1'b0; a_read = 1'b0; b_read = 1'b0; a_be = '0;
    endtask

    task automatic rand_inputs(input int amax);
        a_addr  = AW'($urandom_range(0, amax));
        b_addr  = AW'($urandom_range(0, amax));
        a_wdata = $urandom;
        a_be    = NB'($urandom);
        a_write = 1'($urandom_range(0, 1));
        a_read  = 1'($urandom_range(0, 1));
        b_read  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            rand_inputs(DEPTH - 1);
            tick();
            n++;
        end while (!rdy1 && n < 3000);
        set_idle();
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
        set_idle();
        a_write = 1'b1; a_addr = AW'(addr); a_wdata = data; a_be = be;
        tick();
        set_idle();
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0;
        set_idle();
        repeat (3) tick();

        // clear sweep with traffic that must be ignored
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_cycles", n, 1024);

        a_read = 1'b1; a_addr = AW'(0); b_read = 1'b1; b_addr = AW'(511);
        tick();
        check("init_a0_valid", av1, 1);
        check("init_a0", ad1, 32'h0);
        check("init_b511", bd1, 32'h0);
        a_addr = AW'(1023); b_read = 1'b0;
        tick();
        check("init_a1023", ad1, 32'h0);
        set_idle();

        // byte enables
        write_word(5, 32'hAABBCCDD, 4'b1111);
        write_word(5, 32'h11223344, 4'b0101);
        write_word(5, 32'hFFFFFFFF, 4'b0000);
        a_read = 1'b1; a_addr = AW'(5);
        tick();
        check("be_merge_dut", ad1, 32'hAA22CC44);
        check("be_merge_model", ref_mem[5], 32'hAA22CC44);
        set_idle();

        // read-during-write
        write_word(7, 32'h1, 4'hF);
        a_write = 1'b1; a_addr = AW'(7); a_wdata = 32'h2; a_be = 4'hF;
        a_read = 1'b1; b_read = 1'b1; b_addr = AW'(7);
        #1;
        check("rdw_l0_b_pre_edge", bd0, 32'h1);
        tick();
        check("rdw_read_first_b", bd1, 32'h1);
        check("rdw_read_first_a", ad1, 32'h1);
        set_idle();
        tick();
        check("rdw_write_first_b", bd2, 32'h2);
        check("rdw_write_first_a", ad2, 32'h2);

        // latency sweep: back-to-back reads of 1, 2, 3 on both ports
        write_word(1, 32'h101, 4'hF);
        write_word(2, 32'h202, 4'hF);
        write_word(3, 32'h303, 4'hF);
        a_read = 1'b1; b_read = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_addr = AW'(i); b_addr = AW'(i);
            #1;
            check("lat0_a", ad0, 32'h101 * i);
            check("lat0_b_valid", bv0, 1);
            tick();
            check("lat1_a", ad1, 32'h101 * i);
            check("lat1_b_valid", bv1, 1);
            check("lat2_b_valid", bv2, (i > 1) ? 1 : 0);
            if (i > 1) check("lat2_b", bd2, 32'h101 * (i - 1));
        end
        set_idle();
        tick();
        check("lat1_idle_valid", av1, 0);
        check("lat1_hold", ad1, 32'h303);
        check("lat2_last_valid", bv2, 1);
        check("lat2_last", bd2, 32'h303);

        // randomized traffic; narrow address range half the time for collisions
        for (int c = 0; c < 3000; c++) begin
            rand_inputs(($urandom_range(0, 1) == 1) ? 15 : DEPTH - 1);
            tick();
        end

        // reset with reads in flight
        set_idle();
        a_read = 1'b1; b_read = 1'b1; a_addr = AW'(5); b_addr = AW'(7);
        tick();
        rst_n = 1'b0;
        tick();
        check("flush_l2_a_valid", av2, 0);
        check("flush_l2_b_valid", bv2, 0);
        check("flush_l1_a_rdata", ad1, 32'h0);
        set_idle();

        // mid-sweep reset at count 300
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rand_inputs(DEPTH - 1);
            tick();
        end
        check("mid_sweep_not_ready", rdy1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("resweep_cycles", n, 1024);

        a_read = 1'b1; a_addr = AW'(5); b_read = 1'b1; b_addr = AW'(7);
        tick();
        check("resweep_a5_cleared", ad1, 32'h0);
        check("resweep_b7_cleared", bd1, 32'h0);
        set_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
